systolic_a_feeder: RTL and testbench

- Left-edge transmitter for the 8x8 systolic PE array.
- Buffers one K-deep tile of operand A, delivered one K-slice per beat over a valid/ready stream.
- Replays the tile into the array's row inputs (a_left, enleft) with the diagonal skew the array requires: row i starts i cycles after row 0.
- Pulses tile_done when the last skewed element has been issued.

---
 rtl/systolic_a_feeder.sv | 157 +++++++++++++++
 tb/tb_systolic_a_feeder.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_a_feeder.sv
// ---------------------------------------------------------------------------
// systolic_a_feeder
// Left-edge transmitter for the systolic PE array. Collects one K-deep tile of
// operand A (one K-slice per beat), then replays it into the row inputs with a
// diagonal skew: row i starts i cycles after row 0. tile_done pulses once the
// last skewed element has been presented.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   in_valid   upstream beat valid
//   in_ready   feeder can accept a beat (LOAD only)
//   in_data    beat k: A[i][k] at [i*DW +: DW]
//   stall      array back-pressure, freezes streaming
//   a_left     row i operand at [i*DW +: DW] (registered)
//   enleft     per-row enable (registered)
//   busy       high while streaming
//   tile_done  one-cycle pulse after the last issued element is visible
// ---------------------------------------------------------------------------
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_LOAD   | accepting beats 0..K-1 into the tile buffer
//  ST_STREAM | issuing skewed diagonal t = 0..K+N-2, frozen while stall=1
//  ST_DONE   | clears the row outputs, arms the tile_done pulse
// ---------------------------------------------------------------------------
module systolic_a_feeder #(
   parameter int N  = 8,
   parameter int DW = 4,
   parameter int K  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   input  logic            stall,
   output logic [N*DW-1:0] a_left,
   output logic [N-1:0]    enleft,
   output logic            busy,
   output logic            tile_done
);

   localparam int TL = K + N - 1;
   localparam int BW = (K  > 1) ? $clog2(K)  : 1;
   localparam int TW = (TL > 1) ? $clog2(TL) : 1;

   localparam logic [BW-1:0] BEAT_LAST = BW'(K - 1);
   localparam logic [TW-1:0] T_LAST    = TW'(TL - 1);
   localparam logic [TW:0]   K_EXT     = (TW + 1)'(K);

   localparam logic [1:0] ST_LOAD   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic [TW-1:0]   t_q, t_d;
   logic [N*DW-1:0] a_left_q, a_left_d;
   logic [N-1:0]    enleft_q, enleft_d;
   logic            done_q, done_d;
   logic [N*DW-1:0] buf_q [K];
   logic [TW-1:0]   diff;
   logic            accept;

   // The cycle carrying the tile_done pulse still belongs to the previous tile,
   // so the next LOAD only opens once the pulse has gone. rst is kept out of
   // accept so it never feeds a synchronous flop input.
   assign accept    = in_valid & (state_q == ST_LOAD) & ~done_q;
   assign in_ready  = rst & (state_q == ST_LOAD) & ~done_q;
   assign busy      = (state_q == ST_STREAM);
   assign a_left    = a_left_q;
   assign enleft    = enleft_q;
   assign tile_done = done_q;

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      t_d      = t_q;
      a_left_d = a_left_q;
      enleft_d = '0;
      done_d   = 1'b0;
      diff     = '0;
      case (state_q)
         ST_LOAD: begin
            a_left_d = '0;
            if (accept) begin
               if (beat_q == BEAT_LAST) begin
                  beat_d  = '0;
                  t_d     = '0;
                  state_d = ST_STREAM;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         ST_STREAM: begin
            // On stall, enleft_d stays at its default 0 and a_left holds.
            if (!stall) begin
               for (int i = 0; i < N; i++) begin
                  diff = t_q - TW'(i);
                  if ((t_q >= TW'(i)) && ({1'b0, diff} < K_EXT)) begin
                     enleft_d[i]           = 1'b1;
                     a_left_d[i*DW +: DW]  = buf_q[diff[BW-1:0]][i*DW +: DW];
                  end else begin
                     a_left_d[i*DW +: DW]  = '0;
                  end
               end
               if (t_q == T_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  t_d = t_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            a_left_d = '0;
            done_d   = 1'b1;
            beat_d   = '0;
            t_d      = '0;
            state_d  = ST_LOAD;
         end
         default: begin
            a_left_d = '0;
            beat_d   = '0;
            t_d      = '0;
            state_d  = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_LOAD;
         beat_q   <= '0;
         t_q      <= '0;
         a_left_q <= '0;
         enleft_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         t_q      <= t_d;
         a_left_q <= a_left_d;
         enleft_q <= enleft_d;
         done_q   <= done_d;
      end
   end

   // Tile storage carries no reset; its contents only matter once a full tile
   // has been written.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_q[beat_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_systolic_a_feeder.sv
module tb_systolic_a_feeder;

   localparam int N  = 8;
   localparam int DW = 4;
   localparam int K  = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N*DW-1:0] in_data = '0;
   logic            stall = 1'b0;
   logic [N*DW-1:0] a_left;
   logic [N-1:0]    enleft;
   logic            busy;
   logic            tile_done;

   systolic_a_feeder #(.N(N), .DW(DW), .K(K)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .stall     (stall),
      .a_left    (a_left),
      .enleft    (enleft),
      .busy      (busy),
      .tile_done (tile_done)
   );

   always #5 clk = ~clk;

   int              n_checks = 0;
   int              n_fail   = 0;
   int              cyc      = 0;
   int              done_cnt = 0;
   logic [DW-1:0]   q [N][$];
   int              ena_cnt  [N];
   int              first_en [N];
   bit              seen     [N];
   logic [N*DW-1:0] tile_mem [K];
   logic [DW-1:0]   mon_exp;

   // Scoreboard: every enabled row element must be the next queued value.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            if (enleft[i]) begin
               if (!seen[i]) begin
                  seen[i]     = 1'b1;
                  first_en[i] = cyc;
               end
               ena_cnt[i]++;
               n_checks++;
               if (q[i].size() == 0) begin
                  n_fail++;
                  $display("FAIL row%0d_data: enleft high with a_left=%h, required no element", i, a_left[i*DW +: DW]);
               end else begin
                  mon_exp = q[i].pop_front();
                  if (a_left[i*DW +: DW] !== mon_exp) begin
                     n_fail++;
                     $display("FAIL row%0d_data: got %h, required %h", i, a_left[i*DW +: DW], mon_exp);
                  end
               end
            end
         end
         if (tile_done === 1'b1) begin
            done_cnt++;
            n_checks++;
            if (in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL done_vs_ready: in_ready=%b during tile_done, required 0", in_ready);
            end
         end
      end
   end

   function automatic logic [N*DW-1:0] exp_a(input int t);
      logic [N*DW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if ((t - i >= 0) && (t - i < K)) v[i*DW +: DW] = tile_mem[t - i][i*DW +: DW];
      return v;
   endfunction

   function automatic void clear_stats();
      for (int i = 0; i < N; i++) begin
         ena_cnt[i]  = 0;
         first_en[i] = 0;
         seen[i]     = 1'b0;
      end
   endfunction

   function automatic void flush_q();
      for (int i = 0; i < N; i++) q[i].delete();
   endfunction

   function automatic void push_beat(input int k);
      for (int i = 0; i < N; i++) q[i].push_back(tile_mem[k][i*DW +: DW]);
   endfunction

   function automatic bit all_rows_k();
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < N; i++) if (ena_cnt[i] != K) ok = 1'b0;
      return ok;
   endfunction

   function automatic int q_total();
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += q[i].size();
      return s;
   endfunction

   // Drives beats start..K-1; returns at the negedge after the last acceptance.
   task automatic load_tile(input int start, input int gap_pct);
      int k;
      int guard;
      k = start;
      guard = 0;
      while (k < K && guard < 400) begin
         @(negedge clk);
         guard++;
         in_data  = tile_mem[k];
         in_valid = ($urandom_range(99) >= gap_pct);
         if (in_valid && in_ready) begin
            push_beat(k);
            k++;
         end
      end
      n_checks++;
      if (k != K) begin
         n_fail++;
         $display("FAIL load_timeout: accepted %0d beats, required %0d", k, K);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int max, output int cycles);
      cycles = 0;
      while (tile_done !== 1'b1 && cycles < max) begin
         @(negedge clk);
         cycles++;
      end
      n_checks++;
      if (tile_done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_timeout: no tile_done within %0d cycles", max);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, busy, tile_done, enleft, a_left} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b busy=%b done=%b en=%h a=%h, required all 0",
                  in_ready, busy, tile_done, enleft, a_left);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      int en_cycles;
      for (int k = 0; k < K; k++) tile_mem[k] = {N{4'(k)}};
      clear_stats();
      load_tile(0, 0);
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_enter_stream: ready=%b busy=%b, required 0/1", in_ready, busy);
      end
      en_cycles = 0;
      for (int c = 1; c <= K + N - 1; c++) begin
         @(negedge clk);
         if (enleft != '0) en_cycles++;
         if (c == 1) begin
            n_checks++;
            if (enleft !== 8'h01 || a_left !== exp_a(0)) begin
               n_fail++;
               $display("FAIL basic_t0: en=%h a=%h, required 01/%h", enleft, a_left, exp_a(0));
            end
         end
         if (c == 8) begin
            n_checks++;
            if (enleft !== 8'hFF) begin
               n_fail++;
               $display("FAIL basic_t7: en=%h, required ff", enleft);
            end
         end
         if (c == 15) begin
            n_checks++;
            if (enleft !== 8'h80 || a_left[(N-1)*DW +: DW] !== 4'd7) begin
               n_fail++;
               $display("FAIL basic_t14: en=%h row7=%h, required 80/7", enleft, a_left[(N-1)*DW +: DW]);
            end
         end
      end
      n_checks++;
      if (en_cycles != 15) begin
         n_fail++;
         $display("FAIL basic_en_cycles: got %0d, required 15", en_cycles);
      end
      @(negedge clk);
      n_checks++;
      if (tile_done !== 1'b1 || in_ready !== 1'b0 || enleft !== '0 || a_left !== '0) begin
         n_fail++;
         $display("FAIL basic_done: done=%b ready=%b en=%h a=%h, required 1/0/0/0", tile_done, in_ready, enleft, a_left);
      end
      @(negedge clk);
      n_checks++;
      if (tile_done !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_after_done: done=%b ready=%b, required 0/1", tile_done, in_ready);
      end
   endtask

   task automatic test_unique();
      int w;
      bit skew_ok;
      for (int k = 0; k < K; k++)
         for (int i = 0; i < N; i++) tile_mem[k][i*DW +: DW] = 4'((i + k) & 4'hF);
      clear_stats();
      load_tile(0, 0);
      wait_done(40, w);
      skew_ok = 1'b1;
      for (int i = 0; i < N; i++) if (first_en[i] - first_en[0] != i) skew_ok = 1'b0;
      n_checks++;
      if (!skew_ok) begin
         n_fail++;
         $display("FAIL unique_skew: row7 start offset %0d, required 7", first_en[N-1] - first_en[0]);
      end
      n_checks++;
      if (!all_rows_k()) begin
         n_fail++;
         $display("FAIL unique_counts: row0=%0d row7=%0d, required %0d", ena_cnt[0], ena_cnt[N-1], K);
      end
      @(negedge clk);
      n_checks++;
      if (q_total() != 0) begin
         n_fail++;
         $display("FAIL unique_leftover: %0d elements never issued, required 0", q_total());
      end
   endtask

   task automatic test_stall();
      int w;
      for (int k = 0; k < K; k++) tile_mem[k] = $urandom();
      clear_stats();
      load_tile(0, 0);
      repeat (5) @(negedge clk);
      stall = 1'b1;
      n_checks++;
      if (a_left !== exp_a(4)) begin
         n_fail++;
         $display("FAIL stall_pre: a=%h, required %h", a_left, exp_a(4));
      end
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         n_checks++;
         if (enleft !== '0 || a_left !== exp_a(4)) begin
            n_fail++;
            $display("FAIL stall_hold: cycle %0d en=%h a=%h, required 00/%h", s, enleft, a_left, exp_a(4));
         end
      end
      stall = 1'b0;
      wait_done(40, w);
      n_checks++;
      if (w != 11) begin
         n_fail++;
         $display("FAIL stall_done_delay: done %0d cycles after release, required 11", w);
      end
      n_checks++;
      if (!all_rows_k()) begin
         n_fail++;
         $display("FAIL stall_counts: row0=%0d row7=%0d, required %0d", ena_cnt[0], ena_cnt[N-1], K);
      end
      @(negedge clk);
   endtask

   task automatic test_hold_valid();
      int w;
      for (int k = 0; k < K; k++) tile_mem[k] = {N{4'(k + 3)}};
      clear_stats();
      load_tile(0, 0);
      in_valid = 1'b1;
      in_data  = {N{4'hA}};
      w = 0;
      while (in_ready !== 1'b1 && w < 40) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (w != 17) begin
         n_fail++;
         $display("FAIL hold_ready_gap: in_ready back after %0d cycles, required 17", w);
      end
      tile_mem[0] = {N{4'hA}};
      for (int k = 1; k < K; k++) tile_mem[k] = {N{4'(k * 2)}};
      push_beat(0);
      clear_stats();
      load_tile(1, 0);
      wait_done(40, w);
      n_checks++;
      if (!all_rows_k()) begin
         n_fail++;
         $display("FAIL hold_counts: row0=%0d row7=%0d, required %0d", ena_cnt[0], ena_cnt[N-1], K);
      end
      @(negedge clk);
      n_checks++;
      if (q_total() != 0) begin
         n_fail++;
         $display("FAIL hold_leftover: %0d elements never issued, required 0", q_total());
      end
   endtask

   task automatic test_reset_mid();
      int w;
      for (int k = 0; k < K; k++) tile_mem[k] = $urandom();
      clear_stats();
      load_tile(0, 0);
      repeat (6) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (enleft !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || a_left !== '0) begin
         n_fail++;
         $display("FAIL midrst_async: en=%h busy=%b ready=%b a=%h, required all 0", enleft, busy, in_ready, a_left);
      end
      flush_q();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_release: ready=%b busy=%b, required 1/0", in_ready, busy);
      end
      for (int k = 0; k < K; k++) tile_mem[k] = $urandom();
      clear_stats();
      load_tile(0, 0);
      wait_done(40, w);
      n_checks++;
      if (!all_rows_k()) begin
         n_fail++;
         $display("FAIL midrst_counts: row0=%0d row7=%0d, required %0d", ena_cnt[0], ena_cnt[N-1], K);
      end
      @(negedge clk);
      n_checks++;
      if (q_total() != 0) begin
         n_fail++;
         $display("FAIL midrst_leftover: %0d elements never issued, required 0", q_total());
      end
   endtask

   task automatic test_back_to_back();
      int base;
      int w;
      base = done_cnt;
      for (int j = 0; j < 4; j++) begin
         for (int k = 0; k < K; k++) tile_mem[k] = $urandom();
         load_tile(0, 50);
      end
      w = 0;
      while (done_cnt - base < 4 && w < 200) begin
         @(negedge clk);
         w++;
      end
      repeat (2) @(negedge clk);
      n_checks++;
      if (done_cnt - base != 4) begin
         n_fail++;
         $display("FAIL b2b_done_count: got %0d, required 4", done_cnt - base);
      end
      n_checks++;
      if (q_total() != 0) begin
         n_fail++;
         $display("FAIL b2b_leftover: %0d elements never issued, required 0", q_total());
      end
   endtask

   initial begin
      clear_stats();
      test_reset();
      test_basic();
      test_unique();
      test_stall();
      test_hold_valid();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
